// File: rtl/hyper_pkg.sv
// Shared constants, types and helpers for the hyper block movers.
package hyper_pkg;

    // Cycles from column-address cycle to MCU sampling write data/mask
    localparam int MCU_WR_LAT_DEF  = 2;
    // Cycles from LSAB_READ to LSAB data valid (must stay below MCU_WR_LAT)
    localparam int LSAB_RD_LAT_DEF = 1;
    // An LSAB section raises its EMPTY flag while holding fewer words than this
    localparam int LSAB_AE_THRESH  = 8;
    // Longest block a single ISSUE may request
    localparam int MAX_BLOCK_LEN   = 62;
    // Column counter width: a block may span MAX_BLOCK_LEN+1 words, rounded to even
    localparam int LEN_W           = $clog2(MAX_BLOCK_LEN + 3);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE_COLS = 2'd1,
        S_DRAIN      = 2'd2
    } mv_state_t;

    // Per-column tag carried down the write-latency pipe
    typedef struct packed {
        logic vld;
        logic mask;
    } col_tag_t;

    // Number of DRAM columns touched: words plus leading pad, rounded up to a pair
    function automatic logic [LEN_W-1:0] span_cols(input logic start_odd,
                                                   input logic [5:0] count);
        logic [LEN_W-1:0] span;
        span = LEN_W'(count) + LEN_W'(start_odd);
        span = span + LEN_W'(span[0]);
        return span;
    endfunction

endpackage

// File: rtl/hyper_mvblck_dly.sv
// Write-latency pipe: one {valid,mask} tag per issued column, tapped for the
// LSAB pop (early tap, covering LSAB read latency) and the MCU write mask.
module hyper_mvblck_dly
    import hyper_pkg::*;
#(
    parameter int DEPTH  = MCU_WR_LAT_DEF,
    parameter int RD_TAP = MCU_WR_LAT_DEF - LSAB_RD_LAT_DEF - 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic push,
    input  logic push_mask,
    output logic rd,
    output logic wmask,
    output logic head_busy,
    output logic busy
);

    col_tag_t          tag_in;
    logic [DEPTH-1:0]  vld_q;
    logic [DEPTH-1:0]  mask_q;

    assign tag_in = '{vld: push, mask: push & push_mask};

    // Shift one tag per cycle; an empty slot is inserted when no column is issued
    always_ff @(posedge CLK) begin
        if (!RST) begin
            vld_q  <= '0;
            mask_q <= '0;
        end else begin
            vld_q  <= {vld_q[DEPTH-2:0], tag_in.vld};
            mask_q <= {mask_q[DEPTH-2:0], tag_in.mask};
        end
    end

    // Pad and stopped words never pop the LSAB
    assign rd        = vld_q[RD_TAP] & ~mask_q[RD_TAP];
    assign wmask     = mask_q[DEPTH-1];
    // Anything still ahead of the final data slot
    assign head_busy = |vld_q[DEPTH-2:0];
    assign busy      = |vld_q;

endmodule

// File: rtl/hyper_mvblck_todram.sv
// Block mover, LSAB to DRAM: issues even/odd column pairs to the MCU and pops
// the selected LSAB section in step with the MCU write-data timing.
module hyper_mvblck_todram
    import hyper_pkg::*;
#(
    parameter int MCU_WR_LAT  = MCU_WR_LAT_DEF,
    parameter int LSAB_RD_LAT = LSAB_RD_LAT_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LSAB_0_EMPTY,
    input  logic        LSAB_1_EMPTY,
    input  logic        LSAB_2_EMPTY,
    input  logic        LSAB_3_EMPTY,
    output logic        LSAB_READ,
    output logic [1:0]  LSAB_SECTION,
    input  logic [11:0] START_ADDRESS,
    input  logic [5:0]  COUNT_REQ,
    input  logic [1:0]  SECTION,
    input  logic        ISSUE,
    output logic [5:0]  COUNT_SENT,
    output logic        WORKING,
    output logic [11:0] MCU_COLL_ADDRESS,
    output logic        MCU_WMASK,
    output logic        MCU_REQUEST_ACCESS
);

    mv_state_t        state_q;
    mv_state_t        state_d;
    logic [LEN_W-1:0] len_left_q;
    logic [11:0]      addr_q;
    logic [1:0]       section_q;
    logic [5:0]       count_sent_q;
    logic             first_q;
    logic             lead_pad_q;
    logic             trail_pad_q;
    logic             stop_q;

    logic idle;
    logic active;
    logic accept;
    logic empty_sel;
    logic write_more;
    logic stop_now;
    logic stop_last;
    logic last_col;
    logic advance;
    logic col_mask;
    logic pipe_rd;
    logic pipe_wmask;
    logic pipe_head_busy;
    logic pipe_busy;

    assign idle   = (state_q == S_IDLE);
    assign active = (state_q == S_ISSUE_COLS);
    assign accept = idle & ISSUE & ~pipe_busy;

    // Almost-empty flag of the section currently being drained
    always_comb begin
        case (section_q)
            2'd0:    empty_sel = LSAB_0_EMPTY;
            2'd1:    empty_sel = LSAB_1_EMPTY;
            2'd2:    empty_sel = LSAB_2_EMPTY;
            default: empty_sel = LSAB_3_EMPTY;
        endcase
    end

    // A stop seen on an even column still issues its odd partner (masked);
    // seen on an odd column it makes that column the last one.
    assign write_more = (len_left_q != LEN_W'(1));
    assign stop_now   = active & (stop_q | empty_sel);
    assign stop_last  = stop_now & addr_q[0];
    assign last_col   = active & (~write_more | stop_last);
    assign advance    = active & ~last_col;
    assign col_mask   = (first_q & lead_pad_q) | (~write_more & trail_pad_q) | stop_q;

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // FSM next state: drain until the last tag reaches the final data slot
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (accept)          state_d = S_ISSUE_COLS;
            S_ISSUE_COLS: if (last_col)        state_d = S_DRAIN;
            S_DRAIN:      if (!pipe_head_busy) state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    // FSM outputs: request drops during the last column so ORed requests line up
    always_comb begin
        WORKING            = ~idle;
        MCU_REQUEST_ACCESS = idle ? ISSUE : (active & write_more & ~stop_last);
    end

    // Column address, remaining length and per-block flags
    always_ff @(posedge CLK) begin
        if (!RST) begin
            addr_q      <= '0;
            len_left_q  <= LEN_W'(1);
            section_q   <= '0;
            first_q     <= 1'b0;
            lead_pad_q  <= 1'b0;
            trail_pad_q <= 1'b0;
            stop_q      <= 1'b0;
        end else if (accept) begin
            addr_q      <= {START_ADDRESS[11:1], 1'b0};
            len_left_q  <= span_cols(START_ADDRESS[0], COUNT_REQ);
            section_q   <= SECTION;
            first_q     <= 1'b1;
            lead_pad_q  <= START_ADDRESS[0];
            trail_pad_q <= START_ADDRESS[0] ^ COUNT_REQ[0];
            stop_q      <= 1'b0;
        end else if (active) begin
            if (advance) begin
                addr_q     <= addr_q + 12'd1;
                len_left_q <= len_left_q - LEN_W'(1);
                first_q    <= 1'b0;
            end
            if (empty_sel) stop_q <= 1'b1;
        end
    end

    // Words actually popped from the LSAB for this block
    always_ff @(posedge CLK) begin
        if (!RST)         count_sent_q <= '0;
        else if (accept)  count_sent_q <= '0;
        else if (pipe_rd) count_sent_q <= count_sent_q + 6'd1;
    end

    hyper_mvblck_dly #(
        .DEPTH  (MCU_WR_LAT),
        .RD_TAP (MCU_WR_LAT - LSAB_RD_LAT - 1)
    ) u_dly (
        .CLK       (CLK),
        .RST       (RST),
        .push      (active),
        .push_mask (col_mask),
        .rd        (pipe_rd),
        .wmask     (pipe_wmask),
        .head_busy (pipe_head_busy),
        .busy      (pipe_busy)
    );

    assign LSAB_READ        = pipe_rd;
    assign MCU_WMASK        = pipe_wmask;
    assign LSAB_SECTION     = section_q;
    assign COUNT_SENT       = count_sent_q;
    assign MCU_COLL_ADDRESS = addr_q;

endmodule

// File: tb/tb_hyper_mvblck_todram.sv
// Directed bench for the LSAB-to-DRAM block mover. Cycle 0 is the cycle in
// which ISSUE is presented; outputs are sampled on the falling edge.
module tb_hyper_mvblck_todram;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  emp;
    logic        LSAB_READ;
    logic [1:0]  LSAB_SECTION;
    logic [11:0] START_ADDRESS;
    logic [5:0]  COUNT_REQ;
    logic [1:0]  SECTION;
    logic        ISSUE;
    logic [5:0]  COUNT_SENT;
    logic        WORKING;
    logic [11:0] MCU_COLL_ADDRESS;
    logic        MCU_WMASK;
    logic        MCU_REQUEST_ACCESS;

    int total = 0;
    int bad   = 0;

    logic [15:0] cap_rd;
    logic [15:0] cap_wm;
    logic [15:0] cap_wk;
    logic [15:0] cap_req;
    logic [11:0] cap_addr [16];
    logic [5:0]  cap_cnt_c1;
    logic [5:0]  cap_cnt_end;

    always #5 CLK = ~CLK;

    hyper_mvblck_todram dut (
        .CLK                (CLK),
        .RST                (RST),
        .LSAB_0_EMPTY       (emp[0]),
        .LSAB_1_EMPTY       (emp[1]),
        .LSAB_2_EMPTY       (emp[2]),
        .LSAB_3_EMPTY       (emp[3]),
        .LSAB_READ          (LSAB_READ),
        .LSAB_SECTION       (LSAB_SECTION),
        .START_ADDRESS      (START_ADDRESS),
        .COUNT_REQ          (COUNT_REQ),
        .SECTION            (SECTION),
        .ISSUE              (ISSUE),
        .COUNT_SENT         (COUNT_SENT),
        .WORKING            (WORKING),
        .MCU_COLL_ADDRESS   (MCU_COLL_ADDRESS),
        .MCU_WMASK          (MCU_WMASK),
        .MCU_REQUEST_ACCESS (MCU_REQUEST_ACCESS)
    );

    // Runs 16 cycles starting just after a rising edge, capturing outputs per cycle
    task automatic run_block(input logic [11:0] st, input logic [5:0] cnt,
                             input logic [1:0] sec, input logic hold_issue,
                             input int emp_cyc, input logic [3:0] emp_bits);
        START_ADDRESS = st;
        COUNT_REQ     = cnt;
        SECTION       = sec;
        for (int c = 0; c < 16; c++) begin
            ISSUE = (c == 0) || hold_issue;
            if (c == emp_cyc) emp = emp_bits;
            @(negedge CLK);
            cap_rd[c]   = LSAB_READ;
            cap_wm[c]   = MCU_WMASK;
            cap_wk[c]   = WORKING;
            cap_req[c]  = MCU_REQUEST_ACCESS;
            cap_addr[c] = MCU_COLL_ADDRESS;
            if (c == 1) cap_cnt_c1 = COUNT_SENT;
            @(posedge CLK);
            #1;
        end
        ISSUE       = 1'b0;
        emp         = 4'b0;
        cap_cnt_end = COUNT_SENT;
    endtask

    task automatic test_reset();
        RST = 1'b0; ISSUE = 1'b0; emp = 4'b0;
        START_ADDRESS = 12'h0; COUNT_REQ = 6'd0; SECTION = 2'd0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        total++; if (MCU_COLL_ADDRESS !== 12'h000) begin bad++; $display("FAIL reset_addr got=%h want=000", MCU_COLL_ADDRESS); end
        total++; if ({LSAB_READ, MCU_WMASK, WORKING, MCU_REQUEST_ACCESS} !== 4'b0000) begin bad++;
            $display("FAIL reset_ctl got=%b want=0000", {LSAB_READ, MCU_WMASK, WORKING, MCU_REQUEST_ACCESS}); end
        total++; if ({COUNT_SENT, LSAB_SECTION} !== 8'h00) begin bad++; $display("FAIL reset_cnt_sec got=%h want=00", {COUNT_SENT, LSAB_SECTION}); end
        @(posedge CLK);
        #1;
        RST = 1'b1;
    endtask

    task automatic test_aligned();
        logic [11:0] e;
        run_block(12'h100, 6'd4, 2'd0, 1'b0, -1, 4'b0);
        for (int c = 1; c < 16; c++) begin
            e = 12'h100 + 12'((c > 4) ? 3 : c - 1);
            total++; if (cap_addr[c] !== e) begin bad++; $display("FAIL t1_addr c=%0d got=%h want=%h", c, cap_addr[c], e); end
        end
        total++; if (cap_rd  !== 16'h003C) begin bad++; $display("FAIL t1_read got=%h want=003c", cap_rd); end
        total++; if (cap_wm  !== 16'h0000) begin bad++; $display("FAIL t1_wmask got=%h want=0000", cap_wm); end
        total++; if (cap_wk  !== 16'h007E) begin bad++; $display("FAIL t1_working got=%h want=007e", cap_wk); end
        total++; if (cap_req !== 16'h000F) begin bad++; $display("FAIL t1_req got=%h want=000f", cap_req); end
        total++; if (cap_cnt_end !== 6'd4) begin bad++; $display("FAIL t1_count got=%0d want=4", cap_cnt_end); end
    endtask

    task automatic test_unaligned();
        logic [11:0] e;
        run_block(12'h101, 6'd4, 2'd1, 1'b0, -1, 4'b0);
        for (int c = 1; c < 16; c++) begin
            e = 12'h100 + 12'((c > 6) ? 5 : c - 1);
            total++; if (cap_addr[c] !== e) begin bad++; $display("FAIL t2_addr c=%0d got=%h want=%h", c, cap_addr[c], e); end
        end
        total++; if (cap_cnt_c1 !== 6'd0) begin bad++; $display("FAIL t2_count_clear got=%0d want=0", cap_cnt_c1); end
        total++; if (cap_rd  !== 16'h0078) begin bad++; $display("FAIL t2_read got=%h want=0078", cap_rd); end
        total++; if (cap_wm  !== 16'h0108) begin bad++; $display("FAIL t2_wmask got=%h want=0108", cap_wm); end
        total++; if (cap_wk  !== 16'h01FE) begin bad++; $display("FAIL t2_working got=%h want=01fe", cap_wk); end
        total++; if (cap_req !== 16'h003F) begin bad++; $display("FAIL t2_req got=%h want=003f", cap_req); end
        total++; if (cap_cnt_end !== 6'd4) begin bad++; $display("FAIL t2_count got=%0d want=4", cap_cnt_end); end
    endtask

    task automatic test_stop_odd();
        logic [11:0] e;
        run_block(12'h200, 6'd20, 2'd2, 1'b0, 6, 4'b0100);
        for (int c = 1; c < 16; c++) begin
            e = 12'h200 + 12'((c > 6) ? 5 : c - 1);
            total++; if (cap_addr[c] !== e) begin bad++; $display("FAIL t3_addr c=%0d got=%h want=%h", c, cap_addr[c], e); end
        end
        total++; if (cap_rd  !== 16'h00FC) begin bad++; $display("FAIL t3_read got=%h want=00fc", cap_rd); end
        total++; if (cap_wm  !== 16'h0000) begin bad++; $display("FAIL t3_wmask got=%h want=0000", cap_wm); end
        total++; if (cap_wk  !== 16'h01FE) begin bad++; $display("FAIL t3_working got=%h want=01fe", cap_wk); end
        total++; if (cap_req !== 16'h003F) begin bad++; $display("FAIL t3_req got=%h want=003f", cap_req); end
        total++; if (cap_cnt_end !== 6'd6) begin bad++; $display("FAIL t3_count got=%0d want=6", cap_cnt_end); end
        total++; if (LSAB_SECTION !== 2'd2) begin bad++; $display("FAIL t3_section got=%0d want=2", LSAB_SECTION); end
    endtask

    task automatic test_stop_even();
        logic [11:0] e;
        run_block(12'h400, 6'd8, 2'd0, 1'b0, 3, 4'b0001);
        for (int c = 1; c < 16; c++) begin
            e = 12'h400 + 12'((c > 4) ? 3 : c - 1);
            total++; if (cap_addr[c] !== e) begin bad++; $display("FAIL t3b_addr c=%0d got=%h want=%h", c, cap_addr[c], e); end
        end
        total++; if (cap_rd  !== 16'h001C) begin bad++; $display("FAIL t3b_read got=%h want=001c", cap_rd); end
        total++; if (cap_wm  !== 16'h0040) begin bad++; $display("FAIL t3b_wmask got=%h want=0040", cap_wm); end
        total++; if (cap_wk  !== 16'h007E) begin bad++; $display("FAIL t3b_working got=%h want=007e", cap_wk); end
        total++; if (cap_req !== 16'h000F) begin bad++; $display("FAIL t3b_req got=%h want=000f", cap_req); end
        total++; if (cap_cnt_end !== 6'd3) begin bad++; $display("FAIL t3b_count got=%0d want=3", cap_cnt_end); end
    endtask

    task automatic test_empty_at_issue();
        run_block(12'h500, 6'd6, 2'd1, 1'b0, 0, 4'b0010);
        total++; if (cap_addr[1] !== 12'h500) begin bad++; $display("FAIL t3c_addr1 got=%h want=500", cap_addr[1]); end
        total++; if (cap_addr[9] !== 12'h501) begin bad++; $display("FAIL t3c_addr_last got=%h want=501", cap_addr[9]); end
        total++; if (cap_rd  !== 16'h0004) begin bad++; $display("FAIL t3c_read got=%h want=0004", cap_rd); end
        total++; if (cap_wm  !== 16'h0010) begin bad++; $display("FAIL t3c_wmask got=%h want=0010", cap_wm); end
        total++; if (cap_wk  !== 16'h001E) begin bad++; $display("FAIL t3c_working got=%h want=001e", cap_wk); end
        total++; if (cap_req !== 16'h0003) begin bad++; $display("FAIL t3c_req got=%h want=0003", cap_req); end
        total++; if (cap_cnt_end !== 6'd1) begin bad++; $display("FAIL t3c_count got=%0d want=1", cap_cnt_end); end
    endtask

    task automatic test_other_section();
        logic [11:0] e;
        run_block(12'h300, 6'd10, 2'd3, 1'b0, 2, 4'b0010);
        for (int c = 1; c < 16; c++) begin
            e = 12'h300 + 12'((c > 10) ? 9 : c - 1);
            total++; if (cap_addr[c] !== e) begin bad++; $display("FAIL t4_addr c=%0d got=%h want=%h", c, cap_addr[c], e); end
        end
        total++; if (cap_rd  !== 16'h0FFC) begin bad++; $display("FAIL t4_read got=%h want=0ffc", cap_rd); end
        total++; if (cap_wm  !== 16'h0000) begin bad++; $display("FAIL t4_wmask got=%h want=0000", cap_wm); end
        total++; if (cap_wk  !== 16'h1FFE) begin bad++; $display("FAIL t4_working got=%h want=1ffe", cap_wk); end
        total++; if (cap_req !== 16'h03FF) begin bad++; $display("FAIL t4_req got=%h want=03ff", cap_req); end
        total++; if (cap_cnt_end !== 6'd10) begin bad++; $display("FAIL t4_count got=%0d want=10", cap_cnt_end); end
        total++; if (LSAB_SECTION !== 2'd3) begin bad++; $display("FAIL t4_section got=%0d want=3", LSAB_SECTION); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        run_block(12'h100, 6'd2, 2'd0, 1'b1, -1, 4'b0);
        for (int c = 1; c < 16; c++) begin
            e = ((c % 5) == 1) ? 12'h100 : 12'h101;
            total++; if (cap_addr[c] !== e) begin bad++; $display("FAIL t5_addr c=%0d got=%h want=%h", c, cap_addr[c], e); end
        end
        total++; if (cap_rd  !== 16'h318C) begin bad++; $display("FAIL t5_read got=%h want=318c", cap_rd); end
        total++; if (cap_wk  !== 16'h7BDE) begin bad++; $display("FAIL t5_working got=%h want=7bde", cap_wk); end
        total++; if (cap_req !== 16'h8C63) begin bad++; $display("FAIL t5_req got=%h want=8c63", cap_req); end
        for (int i = 0; i < 40 && WORKING; i++) begin
            @(posedge CLK);
            #1;
        end
        total++; if (WORKING !== 1'b0) begin bad++; $display("FAIL t5_done_timeout got=%b want=0", WORKING); end
        total++; if (COUNT_SENT !== 6'd2) begin bad++; $display("FAIL t5_count got=%0d want=2", COUNT_SENT); end
    endtask

    task automatic test_reset_mid_block();
        START_ADDRESS = 12'h600; COUNT_REQ = 6'd16; SECTION = 2'd3; ISSUE = 1'b1;
        @(posedge CLK); #1; ISSUE = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        total++; if (WORKING !== 1'b1) begin bad++; $display("FAIL t6_running got=%b want=1", WORKING); end
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        total++; if (MCU_COLL_ADDRESS !== 12'h000) begin bad++; $display("FAIL t6_addr got=%h want=000", MCU_COLL_ADDRESS); end
        total++; if ({LSAB_READ, MCU_WMASK, WORKING, MCU_REQUEST_ACCESS} !== 4'b0000) begin bad++;
            $display("FAIL t6_ctl got=%b want=0000", {LSAB_READ, MCU_WMASK, WORKING, MCU_REQUEST_ACCESS}); end
        total++; if ({COUNT_SENT, LSAB_SECTION} !== 8'h00) begin bad++; $display("FAIL t6_cnt_sec got=%h want=00", {COUNT_SENT, LSAB_SECTION}); end
        @(posedge CLK); #1;
        run_block(12'h010, 6'd2, 2'd0, 1'b0, -1, 4'b0);
        total++; if (cap_addr[1] !== 12'h010) begin bad++; $display("FAIL t6_new_addr1 got=%h want=010", cap_addr[1]); end
        total++; if (cap_addr[2] !== 12'h011) begin bad++; $display("FAIL t6_new_addr2 got=%h want=011", cap_addr[2]); end
        total++; if (cap_rd !== 16'h000C) begin bad++; $display("FAIL t6_new_read got=%h want=000c", cap_rd); end
        total++; if (cap_wk !== 16'h001E) begin bad++; $display("FAIL t6_new_working got=%h want=001e", cap_wk); end
        total++; if (cap_cnt_end !== 6'd2) begin bad++; $display("FAIL t6_new_count got=%0d want=2", cap_cnt_end); end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_unaligned();
        test_stop_odd();
        test_stop_even();
        test_empty_at_issue();
        test_other_section();
        test_back_to_back();
        test_reset_mid_block();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
